// File: rtl/babbage_inverse_engine.sv
// babbage_inverse_engine
//   Inverse of the difference-engine evaluator for f(n) = A*n^2 + B*n + C.
//   For a target y it finds the largest n in [0, 2^NW-1] with f(n) <= y by
//   walking f forward one finite-difference step per clock (adders and a
//   comparator only), and reports whether f(n) hits y exactly.
//
// Ports
//   clk_i      rising-edge clock
//   reset_n_i  asynchronous active-low reset
//   start_i    request, sampled only while idle
//   y_i        target value, captured on the accepted start
//   busy_o     high whenever the engine is not idle
//   done_o     one-cycle pulse, results valid
//   n_o        largest n with f(n) <= y
//   f_o        f(n_o)
//   exact_o    f(n_o) == y
//   below_o    y < C, no valid n exists
//   limit_o    search stopped because n reached NMAX
module babbage_inverse_engine #(
    parameter int unsigned A  = 2,
    parameter int unsigned B  = 3,
    parameter int unsigned C  = 5,
    parameter int unsigned NW = 6,
    parameter int unsigned YW = 16
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          start_i,
    input  logic [YW-1:0] y_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [NW-1:0] n_o,
    output logic [YW-1:0] f_o,
    output logic          exact_o,
    output logic          below_o,
    output logic          limit_o
);

    localparam logic [NW-1:0] NMAX  = '1;
    localparam logic [YW-1:0] C_V   = YW'(C);
    localparam logic [YW:0]   AB_V  = (YW+1)'(A + B);
    localparam logic [YW:0]   TWO_A = (YW+1)'(2 * A);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    state_e        state_q, state_d;
    logic [YW-1:0] y_q, y_d;
    logic [YW-1:0] f_q, f_d;
    logic [YW:0]   d_q, d_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] n_o_q, n_o_d;
    logic [YW-1:0] f_o_q, f_o_d;
    logic          exact_q, exact_d;
    logic          below_q, below_d;
    logic          limit_q, limit_d;

    // Candidate next value of f, two bits wider than y so it cannot wrap.
    logic [YW+1:0] f_next;
    logic          step;

    assign f_next = {2'b00, f_q} + {1'b0, d_q};
    // NMAX check first so n never wraps past the top of its range.
    assign step   = (n_q != NMAX) && (f_next <= {2'b00, y_q});

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        f_d     = f_q;
        d_d     = d_q;
        n_d     = n_q;
        n_o_d   = n_o_q;
        f_o_d   = f_o_q;
        exact_d = exact_q;
        below_d = below_q;
        limit_d = limit_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    y_d     = y_i;
                    f_d     = C_V;
                    d_d     = AB_V;
                    n_d     = '0;
                    // Results read as zero until the new answer is latched,
                    // which is also the required value for the below case.
                    n_o_d   = '0;
                    f_o_d   = '0;
                    exact_d = 1'b0;
                    limit_d = 1'b0;
                    below_d = (y_i < C_V);
                    state_d = (y_i < C_V) ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                if (step) begin
                    f_d = f_next[YW-1:0];
                    d_d = d_q + TWO_A;
                    n_d = n_q + 1'b1;
                end else begin
                    n_o_d   = n_q;
                    f_o_d   = f_q;
                    exact_d = (f_q == y_q);
                    limit_d = (n_q == NMAX);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            y_q     <= '0;
            f_q     <= '0;
            d_q     <= '0;
            n_q     <= '0;
            n_o_q   <= '0;
            f_o_q   <= '0;
            exact_q <= 1'b0;
            below_q <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            f_q     <= f_d;
            d_q     <= d_d;
            n_q     <= n_d;
            n_o_q   <= n_o_d;
            f_o_q   <= f_o_d;
            exact_q <= exact_d;
            below_q <= below_d;
            limit_q <= limit_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign n_o     = n_o_q;
    assign f_o     = f_o_q;
    assign exact_o = exact_q;
    assign below_o = below_q;
    assign limit_o = limit_q;

endmodule

// File: tb/tb_babbage_inverse_engine.sv
module tb_babbage_inverse_engine;

    localparam int A    = 2;
    localparam int B    = 3;
    localparam int C    = 5;
    localparam int NW   = 6;
    localparam int YW   = 16;
    localparam int NMAX = (1 << NW) - 1;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic [YW-1:0] y_i = '0;
    logic          busy_o, done_o, exact_o, below_o, limit_o;
    logic [NW-1:0] n_o;
    logic [YW-1:0] f_o;

    babbage_inverse_engine #(.A(A), .B(B), .C(C), .NW(NW), .YW(YW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .y_i(y_i),
        .busy_o(busy_o), .done_o(done_o), .n_o(n_o), .f_o(f_o),
        .exact_o(exact_o), .below_o(below_o), .limit_o(limit_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int t0     = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: brute-force search of f over the whole n range.
    typedef struct {
        int n;
        int f;
        int ex;
        int bl;
        int lim;
    } res_t;

    function automatic res_t model(input int y);
        res_t r;
        r = '{default: 0};
        if (y < C) begin
            r.bl = 1;
            return r;
        end
        for (int n = 0; n <= NMAX; n++) begin
            int fv;
            fv = A * n * n + B * n + C;
            if (fv <= y) begin
                r.n = n;
                r.f = fv;
            end
        end
        r.ex  = (r.f == y) ? 1 : 0;
        r.lim = (r.n == NMAX) ? 1 : 0;
        return r;
    endfunction

    // Transaction-level model: cycles remaining until idle, plus the answer.
    int   cnt = 0;
    res_t exp_r = '{default: 0};

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt   = 0;
            exp_r = '{default: 0};
        end else if (cnt == 0) begin
            if (start_i) begin
                exp_r = model(int'(y_i));
                cnt   = exp_r.bl ? 1 : exp_r.n + 2;
            end
        end else begin
            cnt--;
        end
    end

    // Compare every cycle; results are meaningful in DONE and while idle.
    always @(negedge clk_i) begin
        chk("busy_o", int'(busy_o), (cnt > 0) ? 1 : 0);
        chk("done_o", int'(done_o), (cnt == 1) ? 1 : 0);
        if (cnt <= 1) begin
            chk("n_o",     int'(n_o),     exp_r.n);
            chk("f_o",     int'(f_o),     exp_r.f);
            chk("exact_o", int'(exact_o), exp_r.ex);
            chk("below_o", int'(below_o), exp_r.bl);
            chk("limit_o", int'(limit_o), exp_r.lim);
        end
    end

    task automatic start_pulse(input int y);
        @(negedge clk_i);
        start_i = 1'b1;
        y_i     = YW'(y);
        @(posedge clk_i);
        #1;
        t0      = cyc;
        start_i = 1'b0;
    endtask

    // Literal expectations; latency = cycle index (after start) of done_o.
    task automatic wait_done(input int lat, input int en, input int ef,
                             input int ex, input int eb, input int el);
        int seen;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (seen != 0) begin
            chk("latency",     cyc - t0 + 1,  lat);
            chk("lit_n_o",     int'(n_o),     en);
            chk("lit_f_o",     int'(f_o),     ef);
            chk("lit_exact_o", int'(exact_o), ex);
            chk("lit_below_o", int'(below_o), eb);
            chk("lit_limit_o", int'(limit_o), el);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_n_o",  int'(n_o),    0);
        chk("rst_f_o",  int'(f_o),    0);
        reset_n_i = 1'b1;

        start_pulse(5);     wait_done(2,  0,  5,    1, 0, 0);
        start_pulse(4);     wait_done(1,  0,  0,    0, 1, 0);
        start_pulse(100);   wait_done(8,  6,  95,   0, 0, 0);
        start_pulse(10);    wait_done(3,  1,  10,   1, 0, 0);
        start_pulse(65535); wait_done(65, 63, 8132, 0, 0, 1);
        start_pulse(8132);  wait_done(65, 63, 8132, 1, 0, 1);

        // A second request during SEARCH is dropped.
        start_pulse(100);
        @(negedge clk_i);
        start_i = 1'b1;
        y_i     = 16'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(8, 6, 95, 0, 0, 0);
        // Request in the idle cycle right after DONE is taken.
        start_pulse(5);     wait_done(2, 0, 5, 1, 0, 0);

        // Reset mid-search clears everything at once.
        start_pulse(65535);
        repeat (9) @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_busy",  int'(busy_o),  0);
        chk("arst_done",  int'(done_o),  0);
        chk("arst_n_o",   int'(n_o),     0);
        chk("arst_f_o",   int'(f_o),     0);
        chk("arst_exact", int'(exact_o), 0);
        chk("arst_below", int'(below_o), 0);
        chk("arst_limit", int'(limit_o), 0);
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (60) @(negedge clk_i);
        start_pulse(70);    wait_done(7, 5, 70, 1, 0, 0);

        // Random traffic, including requests while busy and during DONE.
        repeat (3000) begin
            @(negedge clk_i);
            start_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                y_i = YW'($urandom_range(0, 9000));
            else
                y_i = YW'($urandom_range(0, 65535));
        end
        start_i = 1'b0;
        repeat (80) @(negedge clk_i);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
